if_align_stage: RTL

- Instruction-fetch stage of the RV32IC pipeline; produces the IF/ID contents (pc, instruction) for the decode stage.
- Fetches word-aligned 32-bit words from instruction memory and realigns the mixed 16/32-bit RVC stream through a 3-halfword buffer, including instructions straddling a word boundary.
- Accepts a control-flow redirect from the branch-resolving stage and flushes buffered and in-flight fetch data.

---
 rtl/if_align_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/if_align_stage.sv
// rtl/if_align_stage.sv - RV32IC instruction-fetch stage with 16/32-bit realignment buffer
//
// Fetches word-aligned words from instruction memory and realigns the mixed
// compressed/uncompressed stream through a 3-halfword buffer, presenting one
// instruction at a time to decode. A redirect flushes the buffer and any
// in-flight fetch and restarts fetching at the new pc.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/addr/gnt   fetch request handshake (word addresses)
//   imem_rvalid/rdata   fetch response, one per granted request
//   redirect_valid/pc   control-flow redirect from the branch-resolving stage
//   id_valid/ready      handshake towards decode
//   id_pc/instr         head instruction and its pc
//   id_compressed       head instruction is 16-bit

module if_align_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_compressed
);

    logic [2:0][15:0] buf_q;
    logic [1:0]       count_q;
    logic [29:0]      fetch_q;
    logic [31:0]      pc_q;
    logic             outst_q;
    logic             drop_q;
    logic             unal_q;
    logic             run_q;

    logic             head_comp;
    logic             xfer;
    logic             arrive;
    logic [1:0]       cons;
    logic [1:0]       add;
    logic [1:0]       rem;
    logic [2:0]       proj;
    logic [15:0]      hw_lo;
    logic [2:0][15:0] buf_sh;
    logic [2:0][15:0] buf_n;

    // The redirect target is always halfword aligned; its lsb carries no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[0];

    assign head_comp     = buf_q[0][1:0] != 2'b11;
    assign id_valid      = (count_q != 2'd0) && (head_comp || count_q >= 2'd2);
    assign id_compressed = (count_q != 2'd0) && head_comp;
    assign id_instr      = head_comp ? {16'h0000, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign id_pc         = pc_q;
    assign imem_addr     = {fetch_q, 2'b00};

    always_comb begin
        xfer   = id_valid && id_ready && !redirect_valid;
        cons   = xfer ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
        // A stale response (drop flag) or one racing a redirect never enters the buffer.
        arrive = imem_rvalid && !drop_q && !redirect_valid;
        add    = arrive ? (unal_q ? 2'd1 : 2'd2) : 2'd0;
        rem    = count_q - cons;
        proj   = {1'b0, rem} + {1'b0, add};
        hw_lo  = unal_q ? imem_rdata[31:16] : imem_rdata[15:0];

        case (cons)
            2'd1:    buf_sh = {16'h0000, buf_q[2], buf_q[1]};
            2'd2:    buf_sh = {16'h0000, 16'h0000, buf_q[2]};
            default: buf_sh = buf_q;
        endcase

        // Arriving halfwords land right behind what survives the consume.
        buf_n = buf_sh;
        for (int i = 0; i < 3; i++) begin
            if (add != 2'd0 && {1'b0, rem} == 3'(i))
                buf_n[i] = hw_lo;
            if (add == 2'd2 && ({1'b0, rem} + 3'd1) == 3'(i))
                buf_n[i] = imem_rdata[31:16];
        end

        // Only fetch when the projected buffer can absorb a full word.
        imem_req = run_q && (!outst_q || imem_rvalid) && !redirect_valid && (proj <= 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= 2'd0;
            fetch_q <= RESET_PC[31:2];
            pc_q    <= RESET_PC;
            outst_q <= 1'b0;
            drop_q  <= 1'b0;
            unal_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                count_q <= 2'd0;
                pc_q    <= {redirect_pc[31:1], 1'b0};
                fetch_q <= redirect_pc[31:2];
                unal_q  <= redirect_pc[1];
                // A request still in flight belongs to the old stream.
                outst_q <= outst_q && !imem_rvalid;
                drop_q  <= outst_q && !imem_rvalid;
            end else begin
                count_q <= proj[1:0];
                buf_q   <= buf_n;
                if (xfer)
                    pc_q <= pc_q + (head_comp ? 32'd2 : 32'd4);
                if (imem_req && imem_gnt)
                    fetch_q <= fetch_q + 30'd1;
                outst_q <= (imem_req && imem_gnt) || (outst_q && !imem_rvalid);
                if (imem_rvalid)
                    drop_q <= 1'b0;
                if (arrive)
                    unal_q <= 1'b0;
            end
        end
    end

    count_overflow: assert property (@(posedge clk) disable iff (!rst_n) proj <= 3'd3);

endmodule
